// File: rtl/clock_works.sv
// Clock gearbox and reset stretcher: divides CLK by 2^SLOW into clk and holds resetn low for RST_CYCLES slow periods.
// Latency: clk first rises 2^(SLOW-1) CLK edges after RESET release; resetn rises at edge RST_CYCLES*2^SLOW.
// No backpressure; free-running. Define CLOCKWORKS_BENCH_EN to bypass the divider (clk = CLK) for fast simulation.
module clock_works #(
    parameter int SLOW       = 0,
    parameter int RST_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

`ifdef CLOCKWORKS_BENCH_EN
    localparam int ESLOW = 0;
`else
    localparam int ESLOW = SLOW;
`endif

    // A stretch length of zero is treated as one slow period.
    localparam int RC = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int RW = $clog2(RC + 1);

    // High on the CLK edge that ends a slow-clock period.
    logic wrap;

    generate
        if (ESLOW > 0) begin : g_div
            // Power-up value matches the reset value so simulation without RESET is deterministic.
            logic [ESLOW-1:0] div_cnt = '0;

            // Free-running divider; its MSB is a registered, glitch-free 50% duty clock.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            // All-ones means the next edge rolls over to 0, which is also the clk falling edge.
            assign wrap = &div_cnt;
            assign clk  = div_cnt[ESLOW-1];
        end else begin : g_pass
            // No division: every CLK edge is a slow-clock period boundary.
            assign wrap = 1'b1;
            assign clk  = CLK;
        end
    endgenerate

    logic [RW-1:0] rst_cnt  = '0;
    logic          resetn_q = 1'b0;

    // Count slow periods after release; resetn rises on the wrap that reaches RC and holds until RESET.
    // Updating only on wraps keeps resetn stable while clk is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rst_cnt  <= '0;
            resetn_q <= 1'b0;
        end else if (wrap) begin
            if (rst_cnt < RW'(RC)) begin
                rst_cnt <= rst_cnt + 1'b1;
                if (rst_cnt + 1'b1 == RW'(RC)) begin
                    resetn_q <= 1'b1;
                end
            end
        end
    end

    assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_works.sv
// Directed bench for clock_works: three instances (SLOW=2/RC=2, SLOW=3/RC=1, SLOW=0/RC=4) share CLK and RESET.
// Edges are numbered from 1 after RESET release; outputs are sampled 1ns after each rising CLK edge.
// Checks reset state, divided waveform, stretch length, single-cycle reset pulse and long reset hold.
module tb_clock_works;

    logic board_clk;
    logic rst;
    logic clk2, rstn2;
    logic clk3, rstn3;
    logic clk0, rstn0;

    int n_cmp  = 0;
    int n_fail = 0;

    clock_works #(.SLOW(2), .RST_CYCLES(2)) u_s2 (
        .CLK(board_clk), .RESET(rst), .clk(clk2), .resetn(rstn2)
    );
    clock_works #(.SLOW(3), .RST_CYCLES(1)) u_s3 (
        .CLK(board_clk), .RESET(rst), .clk(clk3), .resetn(rstn3)
    );
    clock_works #(.SLOW(0), .RST_CYCLES(4)) u_s0 (
        .CLK(board_clk), .RESET(rst), .clk(clk0), .resetn(rstn0)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    logic prev_rstn3;

    initial begin
        rst = 1'b1;

        // Reset held for 3 edges
        for (int i = 0; i < 3; i++) tick();
        check("rst_clk2", clk2, 1'b0);
        check("rst_rstn2", rstn2, 1'b0);
        check("rst_clk3", clk3, 1'b0);
        check("rst_rstn3", rstn3, 1'b0);
        check("rst_rstn0", rstn0, 1'b0);
        check("rst_clk0_hi", clk0, 1'b1);
        @(negedge board_clk);
        #1;
        check("rst_clk0_lo", clk0, 1'b0);
        @(posedge board_clk);
        #1;

        // Release and run 64 edges
        rst = 1'b0;
        prev_rstn3 = rstn3;
        for (int e = 1; e <= 64; e++) begin
            tick();
            check("run_clk2", clk2, ((e % 4) >= 2) ? 1'b1 : 1'b0);
            check("run_rstn2", rstn2, (e >= 8) ? 1'b1 : 1'b0);
            check("run_clk3", clk3, ((e % 8) >= 4) ? 1'b1 : 1'b0);
            check("run_rstn3", rstn3, (e >= 8) ? 1'b1 : 1'b0);
            check("run_rstn0", rstn0, (e >= 4) ? 1'b1 : 1'b0);
            check("run_clk0", clk0, board_clk);
            if (rstn3 !== prev_rstn3) check("rstn3_chg_clk_low", clk3, 1'b0);
            prev_rstn3 = rstn3;
        end

        // Single-cycle reset pulse mid-operation
        rst = 1'b1;
        tick();
        check("pulse_clk2", clk2, 1'b0);
        check("pulse_rstn2", rstn2, 1'b0);
        check("pulse_clk3", clk3, 1'b0);
        check("pulse_rstn3", rstn3, 1'b0);
        check("pulse_rstn0", rstn0, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check("rel_clk2", clk2, ((e % 4) >= 2) ? 1'b1 : 1'b0);
            check("rel_rstn2", rstn2, (e >= 8) ? 1'b1 : 1'b0);
            check("rel_clk3", clk3, ((e % 8) >= 4) ? 1'b1 : 1'b0);
            check("rel_rstn3", rstn3, (e >= 8) ? 1'b1 : 1'b0);
            check("rel_rstn0", rstn0, (e >= 4) ? 1'b1 : 1'b0);
        end

        // Reset held for 100 edges
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("hold_clk2", clk2, 1'b0);
            check("hold_rstn2", rstn2, 1'b0);
            check("hold_clk3", clk3, 1'b0);
            check("hold_rstn3", rstn3, 1'b0);
            check("hold_rstn0", rstn0, 1'b0);
        end

        // Release again: first slow edge and stretch restart from zero
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("re2_clk2", clk2, ((e % 4) >= 2) ? 1'b1 : 1'b0);
            check("re2_rstn2", rstn2, (e >= 8) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
